// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART receive and transmit sides:
//                the receiver FSM state type, the data width and the default
//                oversampling ratio.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchronizer for the asynchronous serial input,
//                plus a falling-edge detector on the synchronized line.
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous active-low reset
//                rx    - asynchronous serial input, idle high
//                line  - synchronized serial line (resets to 1)
//                fall  - high in the cycle line is 0 and its previous
//                        sample was 1 (0 out of reset)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic line,
  output logic fall
);

  logic meta_q, meta_d;
  logic line_q, line_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = rx;
    line_d = meta_q;
    prev_d = line_q;
  end

  // All three flops reset to the idle level so no edge is seen out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      line_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      line_q <= line_d;
      prev_q <= prev_d;
    end
  end

  assign line = line_q;
  assign fall = prev_q & ~line_q;

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver, 8N1, data bits MSB first. Samples each bit at
//                its centre using a cycle counter started on the falling
//                edge of the start bit.
//  Ports       : clk       - rising-edge clock
//                rst_n     - synchronous active-low reset
//                rx        - asynchronous serial input, idle high
//                rx_data   - last correctly framed byte
//                rx_valid  - one-cycle pulse when rx_data is updated
//                frame_err - one-cycle pulse when the stop bit is 0
//                busy      - high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic line;
  logic fall;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .line  (line),
    .fall  (fall)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update. The counter runs HALF_LAST+1 cycles in
  // START to reach the centre of the start bit, then BIT_LAST+1 cycles per
  // bit so every later sample also lands on a bit centre.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A high sample means the edge was a glitch, not a start bit.
          state_d = line ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          // Shift left so the first (MSB) bit ends up in bit 7.
          shift_d = {shift_q[DATA_BITS-2:0], line};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (line) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    busy      = (state_q != IDLE);
    rx_data   = data_q;
    rx_valid  = valid_q;
    frame_err = err_q;
  end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx with CLKS_PER_BIT=16.
//                Expected pulses (kind, data, cycle) are queued when a frame
//                starts and compared when the DUT pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CPB = 16;
  // Cycles from driving the start-bit low to the result pulse:
  // 2 synchronizer cycles + t0 + CPB/2 + 9*CPB + 1.
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  typedef struct {
    logic [7:0] tx;
    bit         stop;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  vec_t vecs[7];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rx_valid || frame_err) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cyc=%0d valid=%b err=%b data=%02h, required no pulse",
                 cyc, rx_valid, frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_valid !== !e.is_err || frame_err !== e.is_err || rx_data !== e.data ||
            cyc != e.at || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL pulse: got valid=%b err=%b data=%02h cyc=%0d busy=%b, required valid=%b err=%b data=%02h cyc=%0d busy=0",
                   rx_valid, frame_err, rx_data, cyc, busy, !e.is_err, e.is_err, e.data, e.at);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic expect_pulse(input bit is_err, input logic [7:0] data);
    exp_t x;
    x.is_err = is_err;
    x.data   = data;
    x.at     = cyc + LAT;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    step(CPB);
    for (int i = 7; i >= 0; i--) begin
      rx = d[i];
      step(CPB);
    end
    rx = stop;
    step(CPB);
  endtask

  // Idle the line, then require every queued pulse to have been seen.
  task automatic drain(input string name);
    rx = 1'b1;
    step(20);
    check(name, exp_q.size(), 0);
    check({name, "_busy"}, busy, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{8'h5A, 1'b1, 1'b0, 8'h5A};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 8'hFF};
    vecs[5] = '{8'hC3, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{8'h96, 1'b1, 1'b0, 8'h96};

    // Reset state.
    rst_n = 1'b0;
    rx    = 1'b1;
    step(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step(5);

    // Table of frames: good and bad stop bits.
    for (int i = 0; i < 7; i++) begin
      expect_pulse(vecs[i].exp_err, vecs[i].exp_data);
      send_frame(vecs[i].tx, vecs[i].stop);
      drain($sformatf("vec%0d", i));
    end

    // Four-cycle glitch: busy for 8 cycles, then back to idle, no pulse.
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(6);
    check("glitch_busy_hi", busy, 1'b1);
    step(1);
    check("glitch_busy_lo", busy, 1'b0);
    step(20);
    expect_pulse(1'b0, 8'h5A);
    send_frame(8'h5A, 1'b1);
    drain("after_glitch");

    // Back-to-back frames with no idle gap: pulses 160 cycles apart.
    expect_pulse(1'b0, 8'h00);
    send_frame(8'h00, 1'b1);
    expect_pulse(1'b0, 8'hFF);
    send_frame(8'hFF, 1'b1);
    drain("b2b");

    // One-cycle reset during data bit 3 abandons the frame.
    rx = 1'b0;
    step(CPB);
    rx = 1'b1;
    step(CPB);
    rx = 1'b0;
    step(CPB);
    rx = 1'b1;
    step(CPB);
    rx = 1'b0;
    step(8);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    rx    = 1'b1;
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_err", frame_err, 1'b0);
    step(200);
    expect_pulse(1'b0, 8'h81);
    send_frame(8'h81, 1'b1);
    drain("after_reset");

    // Break: 30 bit times low gives exactly one frame error.
    expect_pulse(1'b1, 8'h81);
    rx = 1'b0;
    step(30 * CPB);
    drain("break");
    expect_pulse(1'b0, 8'h7E);
    send_frame(8'h7E, 1'b1);
    drain("after_break");

    step(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
